// File: rtl/btn_evt_pkg.sv
// Shared defaults, widths and helpers for the pushbutton event scheduler.
package btn_evt_pkg;

  localparam int N_BTN_DEF      = 20;
  localparam int LOCKOUT_DEF    = 16;
  localparam int FIFO_DEPTH_DEF = 4;

  localparam int CODE_W = $clog2(N_BTN_DEF);
  typedef logic [CODE_W-1:0] evt_code_t;

  // Round-robin successor of a granted index, wrapping at n-1.
  function automatic int rr_next(input int grant, input int n);
    return (grant == n - 1) ? 0 : grant + 1;
  endfunction

endpackage

// File: rtl/btn_sync_edge_lock.sv
// One button lane: 2-FF synchronizer, rising-edge detector and bounce lockout.
module btn_sync_edge_lock
  import btn_evt_pkg::*;
#(
  parameter int LOCKOUT_CYC = LOCKOUT_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_i,
  output logic accept_o
);

  localparam int LW = $clog2(LOCKOUT_CYC + 1);

  logic          r_s1;
  logic          r_s2;
  logic [LW-1:0] r_lock_cnt;
  logic          w_edge;

  assign w_edge   = r_s1 & ~r_s2;
  assign accept_o = w_edge && (r_lock_cnt == '0);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_s1       <= 1'b0;
      r_s2       <= 1'b0;
      r_lock_cnt <= '0;
    end else begin
      r_s1 <= btn_i;
      r_s2 <= r_s1;
      // Edges seen while counting down are bounce and are discarded here.
      if (accept_o) begin
        r_lock_cnt <= LW'(LOCKOUT_CYC);
      end else if (r_lock_cnt != '0) begin
        r_lock_cnt <= r_lock_cnt - LW'(1);
      end
    end
  end

endmodule

// File: rtl/button_event_scheduler.sv
// Pushbutton front end: per-button debounce lanes, round-robin arbiter and a
// small show-ahead event FIFO drained over valid/ready.
module button_event_scheduler
  import btn_evt_pkg::*;
#(
  parameter int N_BTN       = N_BTN_DEF,
  parameter int LOCKOUT_CYC = LOCKOUT_DEF,
  parameter int FIFO_DEPTH  = FIFO_DEPTH_DEF
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [N_BTN-1:0]           btn_i,
  output logic [$clog2(N_BTN)-1:0]   evt_code,
  output logic                       evt_valid,
  input  logic                       evt_ready,
  output logic [N_BTN-1:0]           pending,
  output logic                       overflow
);

  localparam int EW = $clog2(N_BTN);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  logic [N_BTN-1:0] w_accept;
  logic [N_BTN-1:0] w_grant_oh;
  logic [N_BTN-1:0] w_pending_next;
  logic             w_drop;
  logic             w_grant_valid;
  logic [EW-1:0]    w_grant_idx;
  logic             w_push;
  logic             w_pop;

  logic [N_BTN-1:0] r_pending;
  logic [EW-1:0]    r_rr_ptr;
  logic             r_overflow;
  logic [EW-1:0]    r_mem [FIFO_DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;

  genvar gi;
  generate
    for (gi = 0; gi < N_BTN; gi++) begin : g_lane
      btn_sync_edge_lock #(
        .LOCKOUT_CYC (LOCKOUT_CYC)
      ) u_lane (
        .clk      (clk),
        .reset    (reset),
        .btn_i    (btn_i[gi]),
        .accept_o (w_accept[gi])
      );
      assign w_grant_oh[gi] = w_grant_valid && (w_grant_idx == EW'(gi));
    end
  endgenerate

  // Walk from the farthest offset down so the nearest set bit at/after rr_ptr wins.
  always_comb begin
    int j;
    w_grant_valid = 1'b0;
    w_grant_idx   = '0;
    j             = 0;
    if (r_count < CW'(FIFO_DEPTH)) begin
      for (int k = N_BTN - 1; k >= 0; k--) begin
        j = int'(r_rr_ptr) + k;
        if (j >= N_BTN) begin
          j = j - N_BTN;
        end
        if (r_pending[j]) begin
          w_grant_valid = 1'b1;
          w_grant_idx   = EW'(j);
        end
      end
    end
  end

  // A fresh accept outranks the clear from a same-cycle grant.
  assign w_pending_next = (r_pending & ~w_grant_oh) | w_accept;
  assign w_drop         = |(w_accept & r_pending & ~w_grant_oh);

  assign w_push = w_grant_valid;
  assign w_pop  = (r_count != '0) && evt_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_pending  <= '0;
      r_rr_ptr   <= '0;
      r_overflow <= 1'b0;
    end else begin
      r_pending <= w_pending_next;
      if (w_drop) begin
        r_overflow <= 1'b1;
      end
      if (w_grant_valid) begin
        r_rr_ptr <= EW'(rr_next(int'(w_grant_idx), N_BTN));
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= w_grant_idx;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Head is masked while empty so stale storage never leaks out.
  assign evt_valid = (r_count != '0);
  assign evt_code  = evt_valid ? r_mem[r_rd_ptr] : '0;
  assign pending   = r_pending;
  assign overflow  = r_overflow;

endmodule

// File: tb/tb_button_event_scheduler.sv
// Self-checking bench for button_event_scheduler: vector table plus scoreboarded sequences.
module tb_button_event_scheduler;

  localparam int N     = 20;
  localparam int LOCK  = 16;
  localparam int DEPTH = 4;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic [N-1:0] btn_i = '0;
  logic         evt_ready = 1'b0;
  logic [4:0]   evt_code;
  logic         evt_valid;
  logic [N-1:0] pending;
  logic         overflow;

  int checks = 0;
  int errors = 0;
  int sb[$];
  int mon_exp;

  typedef struct {
    int           idx;
    logic [N-1:0] exp_pend;
    logic [4:0]   exp_code;
  } vec_t;

  vec_t vecs[4];

  always #5 clk = ~clk;

  button_event_scheduler #(
    .N_BTN       (N),
    .LOCKOUT_CYC (LOCK),
    .FIFO_DEPTH  (DEPTH)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .btn_i     (btn_i),
    .evt_code  (evt_code),
    .evt_valid (evt_valid),
    .evt_ready (evt_ready),
    .pending   (pending),
    .overflow  (overflow)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end else begin
      $display("ok   %s = 0x%0h", name, act);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    sb.delete();
    tick(2);
    reset = 1'b0;
  endtask

  task automatic wait_drain(input string name, input int budget);
    int c;
    c = 0;
    while (sb.size() != 0 && c < budget) begin
      tick(1);
      c++;
    end
    chk(name, 32'(sb.size()), 32'd0);
  endtask

  // Every accepted handshake must match the head of the scoreboard.
  always @(negedge clk) begin
    if (!reset && evt_valid && evt_ready) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_evt actual=%0d required=none", evt_code);
      end else begin
        mon_exp = sb.pop_front();
        chk("evt_code", 32'(evt_code), 32'(mon_exp));
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{3,  20'h00008, 5'd3};
    vecs[1] = '{0,  20'h00001, 5'd0};
    vecs[2] = '{19, 20'h80000, 5'd19};
    vecs[3] = '{10, 20'h00400, 5'd10};

    reset = 1'b1;
    tick(3);
    chk("rst_valid", 32'(evt_valid), 32'd0);
    chk("rst_code", 32'(evt_code), 32'd0);
    chk("rst_pending", 32'(pending), 32'd0);
    chk("rst_overflow", 32'(overflow), 32'd0);
    reset = 1'b0;
    tick(1);

    // Single presses: latency, pending timing, head code.
    evt_ready = 1'b1;
    for (int v = 0; v < 4; v++) begin
      btn_i[vecs[v].idx] = 1'b1;
      sb.push_back(vecs[v].idx);
      tick(2);
      chk("lat_pending", 32'(pending), 32'(vecs[v].exp_pend));
      tick(1);
      chk("lat_valid", 32'(evt_valid), 32'd1);
      chk("lat_code", 32'(evt_code), 32'(vecs[v].exp_code));
      tick(1);
      chk("lat_valid_gone", 32'(evt_valid), 32'd0);
      btn_i = '0;
      tick(LOCK + 4);
    end
    wait_drain("single_drain", 5);

    // Bounce on button 5 yields one event; a later clean press yields another.
    btn_i[5] = 1'b1; sb.push_back(5);
    tick(1); btn_i[5] = 1'b0;
    tick(1); btn_i[5] = 1'b1;
    tick(1); btn_i[5] = 1'b0;
    tick(1); btn_i[5] = 1'b1;
    wait_drain("bounce_drain", 20);
    tick(8);
    chk("bounce_valid", 32'(evt_valid), 32'd0);
    chk("bounce_overflow", 32'(overflow), 32'd0);
    btn_i[5] = 1'b0;
    tick(LOCK + 6);
    btn_i[5] = 1'b1; sb.push_back(5);
    wait_drain("bounce_second", 10);
    btn_i = '0;
    tick(4);

    // Round robin from rr_ptr=0, then wrap from 13, then from 8.
    do_reset();
    evt_ready = 1'b1;
    btn_i[2] = 1'b1; btn_i[7] = 1'b1; btn_i[12] = 1'b1;
    sb.push_back(2); sb.push_back(7); sb.push_back(12);
    wait_drain("rr_drain", 20);
    btn_i = '0;
    tick(LOCK + 4);
    btn_i[2] = 1'b1; btn_i[7] = 1'b1;
    sb.push_back(2); sb.push_back(7);
    wait_drain("rr_wrap_drain", 20);
    btn_i = '0;
    tick(LOCK + 4);
    btn_i[3] = 1'b1; btn_i[15] = 1'b1;
    sb.push_back(15); sb.push_back(3);
    wait_drain("rr_ptr8_drain", 20);
    btn_i = '0;
    tick(LOCK + 4);

    // Full FIFO: 0..3 queued, 4 and 5 held pending without overflow.
    do_reset();
    evt_ready = 1'b0;
    btn_i[5:0] = 6'h3f;
    tick(10);
    chk("full_pending", 32'(pending), 32'h30);
    chk("full_valid", 32'(evt_valid), 32'd1);
    chk("full_code", 32'(evt_code), 32'd0);
    chk("full_overflow", 32'(overflow), 32'd0);
    for (int i = 0; i < 6; i++) sb.push_back(i);
    evt_ready = 1'b1;
    wait_drain("full_drain", 30);
    btn_i = '0;
    tick(LOCK + 4);

    // Overflow: repeat press of a button still pending behind a full FIFO.
    do_reset();
    evt_ready = 1'b0;
    btn_i[3:0] = 4'hf; btn_i[9] = 1'b1;
    tick(3);
    btn_i[9] = 1'b0;
    tick(LOCK + 6);
    chk("ovf_pending", 32'(pending), 32'h200);
    chk("ovf_before", 32'(overflow), 32'd0);
    btn_i[9] = 1'b1;
    tick(3);
    chk("ovf_set", 32'(overflow), 32'd1);
    tick(5);
    chk("ovf_sticky", 32'(overflow), 32'd1);
    for (int i = 0; i < 4; i++) sb.push_back(i);
    sb.push_back(9);
    evt_ready = 1'b1;
    wait_drain("ovf_drain", 30);
    btn_i = '0;
    tick(LOCK + 4);
    chk("ovf_after_drain", 32'(overflow), 32'd1);
    do_reset();
    tick(1);
    chk("ovf_cleared", 32'(overflow), 32'd0);

    // Reset mid-stream: 3 queued, 2 pending, then one reset cycle.
    evt_ready = 1'b0;
    btn_i[4:0] = 5'h1f;
    tick(5);
    chk("mid_pending", 32'(pending), 32'h18);
    chk("mid_valid", 32'(evt_valid), 32'd1);
    reset = 1'b1;
    btn_i = '0;
    tick(1);
    chk("mid_rst_valid", 32'(evt_valid), 32'd0);
    chk("mid_rst_pending", 32'(pending), 32'd0);
    chk("mid_rst_overflow", 32'(overflow), 32'd0);
    chk("mid_rst_code", 32'(evt_code), 32'd0);
    reset = 1'b0;
    evt_ready = 1'b1;
    tick(15);
    chk("mid_no_stale", 32'(evt_valid), 32'd0);

    chk("sb_empty", 32'(sb.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/button_event_scheduler.md
Name: button_event_scheduler

Overview:
- Front-end controller for the board's pushbutton bank.
- Each button input gets its own 2-FF synchronizer and rising-edge detector, plus a lockout counter that suppresses contact bounce.
- A round-robin arbiter shares one event path among all buttons and queues button indices into a small show-ahead FIFO.
- Downstream logic drains the FIFO over a valid/ready handshake; there is one event per accepted press.

Parameters:
- N_BTN, 20, number of button inputs (2..32).
- LOCKOUT_CYC, 16, cycles after an accepted edge during which further edges on that button are ignored (≥1).
- FIFO_DEPTH, 4, event queue depth (power of two, ≥2).

Ports:
- clk  in  1  system clock; single clock domain.
- reset  in  1  synchronous, active-high reset.
- btn_i  in  N_BTN  raw asynchronous button levels, 1 = pressed.
- evt_code  out  $clog2(N_BTN)  index of the button at the FIFO head.
- evt_valid  out  1  FIFO non-empty.
- evt_ready  in  1  consumer accepts evt_code this cycle.
- pending  out  N_BTN  accepted-but-not-yet-queued edges.
- overflow  out  1  sticky; an accepted edge was dropped.

Behaviour:
- Reset (synchronous, active-high; any cycle, including mid-operation):
  - clears sync stages, lockout counters, pending, rr_ptr, FIFO pointers and count.
  - outputs after reset: evt_valid=0, evt_code=0, pending=0, overflow=0.
  - in-flight events are discarded.
- Per button i, synchronizer and edge detector:
  - s1[i] <= btn_i[i]; s2[i] <= s1[i].
  - edge[i] = s1[i] & ~s2[i] (combinational).
- Per button i, lockout:
  - an edge is accepted iff lock_cnt[i]==0.
  - on acceptance, lock_cnt[i] <= LOCKOUT_CYC; otherwise it decrements when nonzero, saturating at 0.
  - edges while lock_cnt≠0 are silently ignored; they do not set overflow.
- Pending:
  - an accepted edge sets pending[i] at the next edge.
  - if pending[i] is already 1 and not granted that cycle, the new edge is dropped and overflow <= 1.
  - if it is granted the same cycle, pending[i] stays 1 (set wins over clear).
- Arbiter:
  - each cycle, if pending≠0 and count<FIFO_DEPTH, grant the first set pending bit at or above rr_ptr, searching with wrap-around.
  - on a grant: clear pending[grant], push grant into the FIFO, rr_ptr <= (grant==N_BTN-1) ? 0 : grant+1.
  - at most one grant per cycle.
  - FIFO full → no grant; pending bits hold.
- FIFO (show-ahead):
  - evt_valid = (count≠0); evt_code = mem[rd_ptr].
  - pop on evt_valid & evt_ready; evt_ready while empty is ignored.
  - push and pop in the same cycle: count unchanged, both pointers advance.
  - full-gating uses the registered count; no push into a full FIFO even when a pop occurs that cycle.
  - pointers wrap modulo FIFO_DEPTH.
- Latency: btn_i rises before clock edge k →
  - s1 high after edge k;
  - pending[i] high after edge k+1;
  - FIFO write at edge k+2;
  - evt_valid=1 with evt_code=i after edge k+2.
  - So the first event is visible 3 edges after sampling, when the FIFO is not full and no competitor has priority.
- Releases (falling edges) generate no event.
- overflow is cleared only by reset.

Decomposition:
- Package btn_evt_pkg holds:
  - defaults N_BTN_DEF=20, LOCKOUT_DEF=16, FIFO_DEPTH_DEF=4;
  - localparam CODE_W=$clog2(N_BTN);
  - typedef logic [CODE_W-1:0] evt_code_t.
- Sub-module btn_sync_edge_lock (clk, reset, btn_i, accept_o) contains s1/s2, the edge detector and lock_cnt. It is instantiated N_BTN times via generate.
- Arbiter and FIFO stay in the top module.

Test Plan:
- Reset, then raise btn_i[3] and hold → pending[3]=1 after 2 edges; evt_valid=1, evt_code=3 after 3 edges. With evt_ready=1 there is exactly one event and evt_valid returns to 0.
- Bounce: btn_i[5] toggles 1,0,1,0,1 on consecutive cycles, then holds 1 → exactly one event with code 5. Second press after ≥LOCKOUT_CYC+2 idle cycles → second event.
- Round-robin: buttons 2, 7, 12 rise in the same cycle, evt_ready=1 → events 2, 7, 12 in order. Then 2 and 7 again with rr_ptr=13 → order 2, 7 (wrap).
- Full FIFO: evt_ready=0, buttons 0..5 pressed at once → FIFO holds 0, 1, 2, 3; pending=0x30 held; no overflow. Raise evt_ready → 4 and 5 follow.
- Overflow: evt_ready=0, FIFO full, pending[9]=1; press button 9 again after lockout → overflow=1 and stays 1 until reset.
- Reset mid-stream: 3 events queued and 2 pending, assert reset for 1 cycle → evt_valid=0, pending=0, overflow=0 the next cycle; no stale event appears afterwards.
